forward_ctrl: RTL and testbench

- Forwarding and load-use hazard controller for the 5-stage RV32I pipeline.
- Keeps a shadow copy of destination-register metadata for the EX, MEM and WB stages.
- Drives the 2-bit select codes of the two EX-stage operand 3:1 muxes, and asserts stall toward the IF/ID registers on a load-use hazard.
- Keeps saturating counters of stall cycles and forwarding events.

---
 rtl/forward_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_forward_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage RV32I pipeline.
// Shadows EX/MEM/WB destination metadata, drives operand mux selects, stall, and perf counters.
module forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // EX slot
    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_rs1;
    logic [REG_ADDR_W-1:0] r_ex_rs2;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_reg_write;
    logic                  r_ex_mem_read;
    // MEM slot
    logic                  r_mem_valid;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_reg_write;
    logic                  r_mem_mem_read;
    // WB slot
    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_wb_reg_write;

    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_fwd_cnt;

    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_bubble;
    logic [1:0]            w_fwd_a;
    logic [1:0]            w_fwd_b;
    logic                  w_fwd_any;

    // Youngest producer wins; x0 and non-writing slots never forward.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  mem_valid,
        input logic                  mem_rw,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_valid,
        input logic                  wb_rw,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        logic [1:0] sel;
        if (mem_valid && mem_rw && (mem_rd != REG_ZERO) && (mem_rd == rs)) begin
            sel = SEL_MEM;
        end else if (wb_valid && wb_rw && (wb_rd != REG_ZERO) && (wb_rd == rs)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        if (cnt != CNT_MAX) begin
            nxt = cnt + CNT_ONE;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    // Load-use hazard detection; a flush kills the consumer so it overrides the stall.
    always_comb begin
        w_hazard = 1'b0;
        if (r_ex_valid && r_ex_mem_read && r_ex_reg_write && (r_ex_rd != REG_ZERO) && id_valid &&
            ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2))) begin
            w_hazard = 1'b1;
        end else begin
            w_hazard = 1'b0;
        end
        w_stall  = w_hazard & ~flush;
        w_bubble = flush | w_stall | ~id_valid;
    end

    // Operand mux selects, derived purely from slot state.
    always_comb begin
        w_fwd_a = SEL_RF;
        w_fwd_b = SEL_RF;
        if (r_ex_valid) begin
            w_fwd_a = fwd_sel(r_ex_rs1, r_mem_valid, r_mem_reg_write, r_mem_rd,
                              r_wb_valid, r_wb_reg_write, r_wb_rd);
            w_fwd_b = fwd_sel(r_ex_rs2, r_mem_valid, r_mem_reg_write, r_mem_rd,
                              r_wb_valid, r_wb_reg_write, r_wb_rd);
        end else begin
            w_fwd_a = SEL_RF;
            w_fwd_b = SEL_RF;
        end
        w_fwd_any = (w_fwd_a != SEL_RF) | (w_fwd_b != SEL_RF);
    end

    // Unconditional pipeline advance of the shadow slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid      <= 1'b0;
            r_ex_rs1        <= REG_ZERO;
            r_ex_rs2        <= REG_ZERO;
            r_ex_rd         <= REG_ZERO;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= REG_ZERO;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= REG_ZERO;
            r_wb_reg_write  <= 1'b0;
        end else begin
            r_wb_valid      <= r_mem_valid;
            r_wb_rd         <= r_mem_rd;
            r_wb_reg_write  <= r_mem_reg_write;
            r_mem_valid     <= r_ex_valid;
            r_mem_rd        <= r_ex_rd;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem_read  <= r_ex_mem_read;
            if (w_bubble) begin
                r_ex_valid     <= 1'b0;
                r_ex_rs1       <= REG_ZERO;
                r_ex_rs2       <= REG_ZERO;
                r_ex_rd        <= REG_ZERO;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
            end else begin
                r_ex_valid     <= 1'b1;
                r_ex_rs1       <= id_rs1;
                r_ex_rs2       <= id_rs2;
                r_ex_rd        <= id_rd;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= CNT_ZERO;
            r_fwd_cnt   <= CNT_ZERO;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_fwd_any) begin
                r_fwd_cnt <= sat_inc(r_fwd_cnt);
            end else begin
                r_fwd_cnt <= r_fwd_cnt;
            end
        end
    end

    assign fwd_a     = w_fwd_a;
    assign fwd_b     = w_fwd_b;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: directed test-plan sequences then randomized traffic,
// checked against an instruction-history model; a CNT_W=4 instance exercises saturation.
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b1;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;

    logic [1:0]  fwd_a, fwd_b, fwd_a4, fwd_b4;
    logic        stall, stall4;
    logic [15:0] stall_cnt, fwd_cnt;
    logic [3:0]  stall_cnt4, fwd_cnt4;

    always #5 clk = ~clk;

    forward_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt));

    forward_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall(stall4), .stall_cnt(stall_cnt4), .fwd_cnt(fwd_cnt4));

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr;
    } instr_t;

    typedef struct {
        logic       stall;
        logic [1:0] fa, fb;
        int         scnt, fcnt;
    } exp_t;

    instr_t hist[3];    // instructions currently in EX (0), MEM (1), WB (2)
    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     m_scnt = 0;
    int     m_fcnt = 0;
    logic   last_stall = 1'b0;
    instr_t last_in;

    function automatic instr_t bubble();
        instr_t b;
        b.v = 1'b0; b.rs1 = 5'd0; b.rs2 = 5'd0; b.rd = 5'd0; b.rw = 1'b0; b.mr = 1'b0;
        return b;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (!hist[0].v) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (hist[k].v && hist[k].rw && hist[k].rd != 5'd0 && hist[k].rd == rs)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    // Drive one cycle of inputs and push the expected outputs for that cycle.
    task automatic cycle(input logic r, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        exp_t   e;
        instr_t nx;
        logic   hz;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; flush = fl;
        last_in.v = v; last_in.rs1 = rs1; last_in.rs2 = rs2; last_in.rd = rd;
        last_in.rw = rw; last_in.mr = mr;
        if (r) begin
            for (int k = 0; k < 3; k++) hist[k] = bubble();
            m_scnt = 0; m_fcnt = 0;
            e.stall = 1'b0; e.fa = 2'b00; e.fb = 2'b00; e.scnt = 0; e.fcnt = 0;
            sb.push_back(e);
            last_stall = 1'b0;
        end else begin
            hz = hist[0].v && hist[0].mr && hist[0].rw && hist[0].rd != 5'd0 && v &&
                 (hist[0].rd == rs1 || hist[0].rd == rs2);
            e.stall = hz && !fl;
            e.fa = model_fwd(hist[0].rs1);
            e.fb = model_fwd(hist[0].rs2);
            e.scnt = m_scnt; e.fcnt = m_fcnt;
            sb.push_back(e);
            if (e.stall) m_scnt++;
            if (e.fa != 2'b00 || e.fb != 2'b00) m_fcnt++;
            nx = (fl || e.stall || !v) ? bubble() : last_in;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = nx;
            last_stall = e.stall;
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a response; compare with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall",      int'(stall),      int'(e.stall));
                chk("fwd_a",      int'(fwd_a),      int'(e.fa));
                chk("fwd_b",      int'(fwd_b),      int'(e.fb));
                chk("stall_cnt",  int'(stall_cnt),  sat(e.scnt, 65535));
                chk("fwd_cnt",    int'(fwd_cnt),    sat(e.fcnt, 65535));
                chk("stall4",     int'(stall4),     int'(e.stall));
                chk("stall_cnt4", int'(stall_cnt4), sat(e.scnt, 15));
                chk("fwd_cnt4",   int'(fwd_cnt4),   sat(e.fcnt, 15));
            end
        end
    end

    initial begin
        logic       r, v, rw, mr, fl;
        logic [4:0] a, b, d;
        for (int k = 0; k < 3; k++) hist[k] = bubble();
        last_in = bubble();
        // reset held with a valid decode instruction
        cycle(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        // back-to-back ALU dependency, then one independent instruction between
        cycle(1'b0, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd9, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd11, 1'b1, 1'b0, 1'b0);
        // double producer of x3
        cycle(1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd3, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        // load-use on rs2, re-presented after the stall
        cycle(1'b0, 1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 5'd2, 5'd7, 5'd13, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd2, 5'd7, 5'd13, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        // x0 producers and load to x0
        cycle(1'b0, 1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        // flush against a load-use hazard
        cycle(1'b0, 1'b1, 5'd1, 5'd1, 5'd4, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 5'd4, 5'd2, 5'd15, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        // mid-operation reset with a producer in flight
        cycle(1'b0, 1'b1, 5'd1, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'd6, 5'd6, 5'd2, 1'b1, 1'b0, 1'b0);
        // randomized traffic on a small register set
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 249) == 0);
            if (last_stall && $urandom_range(0, 3) != 0) begin
                v = last_in.v; a = last_in.rs1; b = last_in.rs2; d = last_in.rd;
                rw = last_in.rw; mr = last_in.mr;
            end else begin
                v  = ($urandom_range(0, 7) != 0);
                a  = 5'($urandom_range(0, 7));
                b  = 5'($urandom_range(0, 7));
                d  = 5'($urandom_range(0, 7));
                rw = ($urandom_range(0, 3) != 0);
                mr = ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            cycle(r, v, a, b, d, rw, mr, fl);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
